// File: rtl/synth_pkg.sv
// Shared audio-path constants and types for the synth voice mixer and its I2S transmitter.
// Latency: n/a (declarations only). Backpressure: n/a.
// Also holds the elaboration-time legality check for the transmitter parameters.
package synth_pkg;

    localparam int BITWIDTH      = 24;
    localparam int I2S_SLOT_BITS = 32;
    localparam int I2S_CLK_DIV   = 16;

    typedef struct packed {
        logic lrclk;
        logic sdata;
    } i2s_pins_t;

    localparam i2s_pins_t I2S_PINS_IDLE = '{lrclk: 1'b1, sdata: 1'b0};

    // A slot must hold the one-bit I2S delay plus the whole sample, and the
    // BCLK half-period needs at least two ctl_clk cycles.
    function automatic bit i2s_params_ok(input int bitwidth, input int slot_bits,
                                         input int clk_div);
        return (bitwidth >= 1) && (slot_bits >= bitwidth + 1) && (clk_div >= 2);
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock generator: integer divider of ctl_clk, plus a strobe marking the BCLK falling edge.
// Latency: first BCLK rise CLK_DIV cycles after reset/enable; fall_evt is combinational, valid in the cycle before BCLK drops.
// Backpressure: none; free-running while en is high, held at reset values while en is low.
module i2s_bclk_gen #(
    parameter int CLK_DIV = synth_pkg::I2S_CLK_DIV
) (
    input  logic ctl_clk,
    input  logic ctl_rst,
    input  logic en,
    output logic bclk,
    output logic fall_evt
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);
    // Asserted in the cycle whose closing edge drives bclk 1 -> 0.
    assign fall_evt = en && div_wrap && bclk;

    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bclk <= ~bclk;
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: latches one mono sample per frame and sends it MSB-first in both slots.
// Latency: MSB on i2s_sdata 2*CLK_DIV cycles after capture; aud_freq pulses one cycle after each capture.
// Backpressure: none; paces the upstream mixer with aud_freq, sample_in must be stable by the next capture.
module i2s_tx #(
    parameter int BITWIDTH  = synth_pkg::BITWIDTH,
    parameter int SLOT_BITS = synth_pkg::I2S_SLOT_BITS,
    parameter int CLK_DIV   = synth_pkg::I2S_CLK_DIV
) (
    input  logic                ctl_clk,
    input  logic                ctl_rst,
    input  logic                en,
    input  logic [BITWIDTH-1:0] sample_in,
    output logic                aud_freq,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata
);

    import synth_pkg::*;

    generate
        if (!i2s_params_ok(BITWIDTH, SLOT_BITS, CLK_DIV)) begin : g_bad_params
            $error("i2s_tx: need SLOT_BITS >= BITWIDTH+1 and CLK_DIV >= 2");
        end
    endgenerate

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BCW        = $clog2(FRAME_BITS);
    localparam logic [BCW-1:0] BIT_LAST    = BCW'(FRAME_BITS - 1);
    localparam logic [BCW-1:0] RIGHT_FIRST = BCW'(SLOT_BITS);

    logic                 fall_evt;
    logic                 frame_wrap;
    logic [BCW-1:0]       bit_cnt;
    logic [BCW-1:0]       bit_cnt_nxt;
    logic [BCW-1:0]       slot_bit;
    logic [BITWIDTH-1:0]  hold;
    logic [SLOT_BITS-1:0] slot_word;
    logic [SLOT_BITS-1:0] slot_shift;
    i2s_pins_t            pins;
    i2s_pins_t            pins_nxt;

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .ctl_clk  (ctl_clk),
        .ctl_rst  (ctl_rst),
        .en       (en),
        .bclk     (i2s_bclk),
        .fall_evt (fall_evt)
    );

    // Slot layout, MSB of the vector sent first: one delay bit, the sample, zero padding.
    always_comb begin
        frame_wrap     = (bit_cnt == BIT_LAST);
        bit_cnt_nxt    = frame_wrap ? '0 : bit_cnt + 1'b1;
        pins_nxt.lrclk = (bit_cnt_nxt >= RIGHT_FIRST);
        slot_bit       = pins_nxt.lrclk ? bit_cnt_nxt - RIGHT_FIRST : bit_cnt_nxt;
        slot_word      = SLOT_BITS'({1'b0, hold}) << (SLOT_BITS - BITWIDTH - 1);
        slot_shift     = slot_word << slot_bit;
        pins_nxt.sdata = slot_shift[SLOT_BITS-1];
    end

    // On the wrap edge slot bit 0 is the delay bit, so the new hold value is not needed yet.
    always_ff @(posedge ctl_clk or negedge ctl_rst) begin
        if (!ctl_rst) begin
            bit_cnt  <= BIT_LAST;
            hold     <= '0;
            pins     <= I2S_PINS_IDLE;
            aud_freq <= 1'b0;
        end else if (!en) begin
            bit_cnt  <= BIT_LAST;
            hold     <= '0;
            pins     <= I2S_PINS_IDLE;
            aud_freq <= 1'b0;
        end else begin
            aud_freq <= fall_evt && frame_wrap;
            if (fall_evt) begin
                bit_cnt <= bit_cnt_nxt;
                pins    <= pins_nxt;
                if (frame_wrap) begin
                    hold <= sample_in;
                end
            end
        end
    end

    assign i2s_lrclk = pins.lrclk;
    assign i2s_sdata = pins.sdata;

endmodule
